// File: rtl/inst_loader_pkg.sv
// rtl/inst_loader_pkg.sv - shared bus widths, FSM encoding and defaults for inst_loader
//
// Purpose: common definitions imported by inst_loader and inst_loader_wr_stage.
// Contents: InstAddrBus/InstBus widths, loader state encoding, default base address.
package inst_loader_pkg;

  localparam int INST_ADDR_BUS = 32;
  localparam int INST_BUS      = 32;

  localparam logic [INST_ADDR_BUS-1:0] DEFAULT_BASE_ADDR = 32'h0000_0000;

  // ST_CSUM is only reachable when INST_LOADER_CHECKSUM_EN is defined.
  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_DATA = 3'd1,
    ST_CSUM = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

endpackage

// File: rtl/inst_loader_wr_stage.sv
// rtl/inst_loader_wr_stage.sv - registered instruction-memory write stage
//
// Purpose: turns a one-cycle write request (word index + data) into a registered
// write strobe, byte address and data one cycle later. Address and data hold
// their last values while no write is requested.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   wr_en         write request this cycle
//   idx           word index within the image
//   data          word to write
//   we            registered write strobe
//   addr          registered byte address (BASE_ADDR + 4*idx, wraps mod 2^32)
//   wdata         registered write data
module inst_loader_wr_stage
  import inst_loader_pkg::*;
#(
  parameter logic [INST_ADDR_BUS-1:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int                       CNT_W     = 13
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [CNT_W-1:0]         idx,
  input  logic [INST_BUS-1:0]      data,
  output logic                     we,
  output logic [INST_ADDR_BUS-1:0] addr,
  output logic [INST_BUS-1:0]      wdata
);

  logic [INST_ADDR_BUS-1:0] addr_next;

  always_comb begin
    addr_next = BASE_ADDR + (INST_ADDR_BUS'(idx) << 2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we    <= 1'b0;
      addr  <= '0;
      wdata <= '0;
    end else begin
      we <= wr_en;
      if (wr_en) begin
        addr  <= addr_next;
        wdata <= data;
      end
    end
  end

endmodule

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - program image loader driving the instruction-memory write port
//
// Purpose: receives a length-prefixed program image as a 32-bit word stream,
// writes it word-by-word into instruction memory and releases the core reset
// once the last write has landed. Optional macro INST_LOADER_CHECKSUM_EN adds
// a trailing checksum word (32-bit sum of data words) that must match.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   load_valid_i   stream word valid
//   load_data_i    stream word (header length, data, optional checksum)
//   load_ready_o   block accepts a word this cycle (registered)
//   mem_we_o       instruction-memory write strobe, one cycle per word
//   mem_addr_o     byte address of the write
//   mem_wdata_o    write data
//   core_rst_o     reset to the core, active-high
//   done_o         load completed successfully (sticky)
//   err_o          load aborted (sticky)
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter logic [INST_ADDR_BUS-1:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int                       MAX_WORDS = 4096,
  parameter int                       CNT_W     = 13
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     load_valid_i,
  input  logic [INST_BUS-1:0]      load_data_i,
  output logic                     load_ready_o,
  output logic                     mem_we_o,
  output logic [INST_ADDR_BUS-1:0] mem_addr_o,
  output logic [INST_BUS-1:0]      mem_wdata_o,
  output logic                     core_rst_o,
  output logic                     done_o,
  output logic                     err_o
);

  state_e           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [CNT_W-1:0] len, len_next;
  logic             ready, ready_next;
  logic             done, done_next;
  logic             xfer;
  logic             wr_en;
  logic             hdr_bad;
  logic             last_word;

`ifdef INST_LOADER_CHECKSUM_EN
  logic [INST_BUS-1:0] sum, sum_next;
`endif

  assign xfer      = load_valid_i && ready;
  assign hdr_bad   = (load_data_i == '0) || (load_data_i > INST_BUS'(MAX_WORDS));
  assign last_word = (cnt == (len - CNT_W'(1)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_HDR;
      cnt   <= '0;
      len   <= '0;
      ready <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      len   <= len_next;
      ready <= ready_next;
      done  <= done_next;
    end
  end

`ifdef INST_LOADER_CHECKSUM_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum <= '0;
    end else begin
      sum <= sum_next;
    end
  end
`endif

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    len_next   = len;
    wr_en      = 1'b0;
    // On the plain path done follows the DONE state by one cycle, so the
    // final write strobe precedes the core reset release.
    done_next  = (state == ST_DONE);
`ifdef INST_LOADER_CHECKSUM_EN
    sum_next   = sum;
`endif

    case (state)
      ST_HDR: begin
        if (xfer) begin
          if (hdr_bad) begin
            state_next = ST_ERR;
          end else begin
            state_next = ST_DATA;
            cnt_next   = '0;
            len_next   = load_data_i[CNT_W-1:0];
`ifdef INST_LOADER_CHECKSUM_EN
            sum_next   = '0;
`endif
          end
        end
      end

      ST_DATA: begin
        if (xfer) begin
          wr_en    = 1'b1;
          cnt_next = cnt + CNT_W'(1);
`ifdef INST_LOADER_CHECKSUM_EN
          sum_next = sum + load_data_i;
          if (last_word) begin
            state_next = ST_CSUM;
          end
`else
          if (last_word) begin
            state_next = ST_DONE;
          end
`endif
        end
      end

`ifdef INST_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (xfer) begin
          if (load_data_i == sum) begin
            state_next = ST_DONE;
            // Memory was already written; release on the checksum edge.
            done_next  = 1'b1;
          end else begin
            state_next = ST_ERR;
          end
        end
      end
`endif

      ST_DONE: begin
        state_next = ST_DONE;
      end

      ST_ERR: begin
        state_next = ST_ERR;
      end

      default: begin
        state_next = ST_ERR;
      end
    endcase

    ready_next = (state_next == ST_HDR) || (state_next == ST_DATA)
`ifdef INST_LOADER_CHECKSUM_EN
                 || (state_next == ST_CSUM)
`endif
                 ;
  end

  inst_loader_wr_stage #(
    .BASE_ADDR (BASE_ADDR),
    .CNT_W     (CNT_W)
  ) u_wr_stage (
    .clk   (clk_i),
    .rst   (rst_i),
    .wr_en (wr_en),
    .idx   (cnt),
    .data  (load_data_i),
    .we    (mem_we_o),
    .addr  (mem_addr_o),
    .wdata (mem_wdata_o)
  );

  assign load_ready_o = ready;
  assign done_o       = done;
  assign core_rst_o   = ~done;
  assign err_o        = (state == ST_ERR);

endmodule
